// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- clocked data memory behind the load/store path.
//
// A DEPTH x 32-bit array with a single-outstanding valid/ready request port
// and a response that is held until the consumer takes it. Loads return
// byte/half/word data with sign or zero extension. Stores write through
// per-lane byte enables. Misaligned, out-of-range and illegal-size accesses
// are flagged and never touch the array. After every reset a hardware sweep
// zero-clears the array before the first request is accepted.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of two, 4..4096)
//   ADDR_W  width of the byte address
//   RD_LAT  cycles from accept to resp_valid (1..4)
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   req_valid     request present
//   req_ready     controller can accept a request (IDLE only)
//   req_wr        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  zero-extend loads when 1, sign-extend when 0
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   resp_valid    response present
//   resp_ready    consumer takes the response
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      access was misaligned, out of range or illegal size
//   init_done     clear sweep complete
module dmem_ctrl #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;
  // One bit wider than the address so DEPTH*4 is representable even when
  // the array fills the whole address space.
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH * 4);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  logic [31:0]      mem [DEPTH];
  state_t           state;
  logic [IDX_W-1:0] init_idx;
  logic [CNT_W-1:0] wait_cnt;

  // Size/alignment legality; out-of-range is checked separately.
  function automatic logic size_err(input logic [1:0] size, input logic [1:0] lane);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = lane[0];
      2'b10:   e = |lane;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across the lanes so the byte
  // enables alone pick what lands in the array.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Lane select plus sign/zero extension of a load.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode, valid only in the accept cycle.
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic             req_err;
  logic             accept;
  logic             store_en;
  logic [31:0]      load_result;

  always_comb begin
    req_idx     = req_addr[IDX_W+1:2];
    req_lane    = req_addr[1:0];
    req_err     = size_err(req_size, req_lane) | ({1'b0, req_addr} >= ADDR_LIM);
    accept      = req_valid & req_ready & (state == IDLE);
    store_en    = accept & req_wr & ~req_err;
    load_result = (req_wr | req_err) ? 32'd0
                : load_extend(mem[req_idx], req_size, req_lane, req_unsigned);
  end

  // Single write port shared by the clear sweep and committed stores; the
  // two never coincide because stores are only accepted in IDLE.
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wd;

  always_comb begin
    mem_we   = store_en;
    mem_be   = store_be(req_size, req_lane);
    mem_widx = req_idx;
    mem_wd   = store_data(req_size, req_wdata);
    if (state == INIT) begin
      // Held in reset the sweep must not touch the array.
      mem_we   = reset;
      mem_be   = 4'b1111;
      mem_widx = init_idx;
      mem_wd   = 32'd0;
    end
  end

  // Array write stage (data only, no reset).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_widx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  // Control FSM; the response is captured at the accept edge and held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      init_idx   <= '0;
      wait_cnt   <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(DEPTH - 1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_rdata <= load_result;
            resp_err   <= req_err;
            wait_cnt   <= '0;
            if (RD_LAT == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // RD_LAT-1 cycles here, so resp_valid lands RD_LAT after accept.
          if (wait_cnt == CNT_W'(RD_LAT - 2)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised, clocked data memory with a valid/ready request port and a held response port. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. Flags misaligned and out-of-range accesses as errors. After every reset it runs a hardware sweep that zero-clears the array. It is the successor data memory behind the processor's load/store path and replaces the combinational, file-initialised store.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 4..4096.
ADDR_W, 32, width of the byte address port.
RD_LAT, 1, cycles from request acceptance to resp_valid; legal range 1..4.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_wr  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  input  1  load zero-extend when 1, sign-extend when 0; ignored on stores.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  output  1  response present.
resp_ready  input  1  consumer takes the response.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_err  output  1  access was misaligned, out of range or illegal size.
init_done  output  1  clear sweep complete.

Behaviour:
- Reset (reset=0, asynchronous): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, state=INIT, sweep index=0. Array contents are not cleared by the reset itself.
- States: INIT, IDLE, WAIT, RESP.
- INIT: writes 0 to word[idx] each cycle, idx increments. After the write to DEPTH-1, goes to IDLE and init_done=1, exactly DEPTH cycles after reset release. req_ready=0 throughout INIT.
- IDLE: req_ready=1. An accept (req_valid & req_ready) latches the request.
  - If RD_LAT=1, goes to RESP.
  - Otherwise goes to WAIT, where a counter runs RD_LAT-1 cycles, then RESP.
- Timing: resp_valid rises exactly RD_LAT cycles after the accept edge.
- req_ready is 0 in WAIT and RESP: one outstanding request at a time.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready=1. On resp_valid & resp_ready, goes to IDLE with resp_valid=0. There is no accept in that same cycle; the earliest next accept is the following cycle.
- Error checks:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - req_size=11 is illegal.
  - addr >= DEPTH*4 is out of range.
  - Any of these gives resp_err=1 and resp_rdata=0, with no array write.
- Word index is addr[log2(DEPTH)+1:2].
- Store: commits at the accept edge using byte enables.
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes addr[1]*2 and +1 get wdata[15:0], little-endian.
  - word: all four lanes.
  - Other lanes are unchanged. Response has resp_rdata=0, resp_err=0.
- Load: the word is read at the accept edge, then the lane is selected and extended.
  - byte from lane addr[1:0], bit 7 extended unless req_unsigned.
  - half from addr[1], bit 15 extended unless req_unsigned.
  - word is passed through unchanged.
- Single outstanding request means there are no read-after-write hazards.
- Reset mid-operation: any in-flight response is dropped, resp_valid goes to 0 immediately, and INIT restarts from idx 0. A store already accepted stays committed, but INIT then clears it.
- req_* inputs outside an accept are ignored. req_valid in INIT is held by the requester, not dropped.

Test Plan:
- Init: release reset at cycle 0 with DEPTH=64. Expect init_done=1 and req_ready=1 at cycle 64. Load word at 0x0FC returns 0x00000000.
- Word round trip, RD_LAT=1: store 0xDEADBEEF at 0x010, then load word at 0x010. resp_valid rises 1 cycle after the accept, with resp_rdata=0xDEADBEEF and resp_err=0.
- Byte/half extension: after the round trip above, store byte 0x80 at 0x011, making word 0xDEAD80EF.
  - Signed byte load at 0x011 returns 0xFFFFFF80; unsigned returns 0x00000080.
  - Signed half load at 0x012 returns 0xFFFFDEAD.
- Errors:
  - Word load at 0x006 gives resp_err=1, resp_rdata=0.
  - Half store of 0x1234 at 0x013 gives resp_err=1, and word 0x010 stays unchanged.
  - Load at 0x100 (DEPTH=64) gives resp_err=1.
  - req_size=11 gives resp_err=1.
- Backpressure and latency: with RD_LAT=3, resp_valid rises 3 cycles after the accept. Hold resp_ready=0 for 5 cycles and check resp_rdata is stable and req_ready=0. resp_ready=1 then clears resp_valid on the next edge, and req_ready=1 the cycle after.
- Reset mid-op: assert reset while in WAIT. Expect resp_valid=0 and init_done=0 at once, INIT to rerun for DEPTH cycles, and a prior store to read back 0.
